// File: rtl/mul16_sched_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
// SIGNED_MUL_EN (when defined) makes the top treat operands as two's
// complement; mag16 below is only referenced in that build.
package mul16_sched_pkg;

    localparam int MUL_W       = 16;
    localparam int PROD_W      = 32;
    localparam int TIMEOUT_DEF = 31;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        RUN     = 3'd2,
        RESP    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    // Magnitude of a 16-bit two's complement value; -32768 maps to 16'h8000,
    // which the unsigned multiplier handles correctly.
    function automatic logic [MUL_W-1:0] mag16(input logic [MUL_W-1:0] v);
        return v[MUL_W-1] ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/mul16_rr_sched_arb.sv
// Combinational round-robin arbiter: the first requester strictly after
// ptr (wrapping to 0) wins.
module rr_arbiter_n #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  id,
    output logic            any
);

    logic [IDW-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest hit after ptr wins.
    always_comb begin
        onehot = '0;
        id     = '0;
        cand   = '0;
        any    = |req;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (req[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                id           = cand;
            end
        end
    end

endmodule

// File: rtl/mul16_rr_sched.sv
// Round-robin scheduler sharing one sequential 16x16 multiplier among NREQ
// requesters, with a watchdog on the multiplier done pulse.
// Optional build macro: SIGNED_MUL_EN (two's complement operands).
//
// state   | meaning
// IDLE    | waiting for any request
// GRANT   | gnt pulse, winner's operands captured into mul_ain/mul_bin
// RUN     | mul_start held, waiting for mul_done or watchdog expiry
// RESP    | rsp_valid pulse, mul_start still held
// RELEASE | mul_start dropped so the multiplier rewinds
module mul16_rr_sched
    import mul16_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [16*NREQ-1:0]    ain_flat,
    input  logic [16*NREQ-1:0]    bin_flat,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  mul_start,
    output logic [15:0]           mul_ain,
    output logic [15:0]           mul_bin,
    input  logic [31:0]           mul_yout,
    input  logic                  mul_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state, state_nxt;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     id_q;
    logic [CNT_W-1:0]   cnt;
    logic [NREQ-1:0]    arb_onehot;
    logic [IDW-1:0]     arb_id;
    logic               arb_any;
    logic [MUL_W-1:0]   sel_a, sel_b;
    logic               tmo_hit;
`ifdef SIGNED_MUL_EN
    logic               sign_q;
`endif

    // Arbitration is re-evaluated in GRANT so a requester that dropped req
    // after IDLE is never granted.
    rr_arbiter_n #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req),
        .ptr    (ptr),
        .onehot (arb_onehot),
        .id     (arb_id),
        .any    (arb_any)
    );

    assign sel_a   = ain_flat[int'(arb_id)*MUL_W +: MUL_W];
    assign sel_b   = bin_flat[int'(arb_id)*MUL_W +: MUL_W];
    assign tmo_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign rsp_id  = id_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; mul_done wins over a simultaneous watchdog expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any) state_nxt = GRANT;
            GRANT:   state_nxt = arb_any ? RUN : IDLE;
            RUN:     if (mul_done || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore-style outputs decoded from state; gnt follows the live arbiter.
    always_comb begin
        gnt       = (state == GRANT) ? arb_onehot : '0;
        mul_start = (state == RUN) || (state == RESP);
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // Operand capture, watchdog counter, product capture and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= IDW'(NREQ - 1);
            id_q        <= '0;
            cnt         <= '0;
            mul_ain     <= '0;
            mul_bin     <= '0;
            rsp_data    <= '0;
            err_timeout <= 1'b0;
`ifdef SIGNED_MUL_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            case (state)
                GRANT: begin
                    if (arb_any) begin
`ifdef SIGNED_MUL_EN
                        mul_ain <= mag16(sel_a);
                        mul_bin <= mag16(sel_b);
                        sign_q  <= sel_a[MUL_W-1] ^ sel_b[MUL_W-1];
`else
                        mul_ain <= sel_a;
                        mul_bin <= sel_b;
`endif
                        id_q    <= arb_id;
                        ptr     <= arb_id;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mul_done) begin
`ifdef SIGNED_MUL_EN
                        rsp_data <= sign_q ? (~mul_yout + 32'd1) : mul_yout;
`else
                        rsp_data <= mul_yout;
`endif
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        rsp_data    <= '0;
                    end
                end
                RELEASE: cnt <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_rr_sched.sv
// Scoreboard bench for mul16_rr_sched with a behavioural multiplier stub.
module tb_mul16_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TO   = 31;
    localparam int NOM_LAT = 19;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [16*NREQ-1:0]  ain_flat = '0;
    logic [16*NREQ-1:0]  bin_flat = '0;
    logic [NREQ-1:0]     gnt;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_data;
    logic                busy;
    logic                err_timeout;
    logic                mul_start;
    logic [15:0]         mul_ain;
    logic [15:0]         mul_bin;
    logic [31:0]         mul_yout;
    logic                mul_done;

    always #5 clk = ~clk;

    mul16_rr_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ain_flat(ain_flat), .bin_flat(bin_flat),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .err_timeout(err_timeout), .mul_start(mul_start),
        .mul_ain(mul_ain), .mul_bin(mul_bin), .mul_yout(mul_yout), .mul_done(mul_done)
    );

    // Multiplier stub: done pulses 17 cycles after start rises, unless stuck.
    int stp;
    bit stuck = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stp <= 0; mul_done <= 1'b0; mul_yout <= '0;
        end else if (!mul_start) begin
            stp <= 0; mul_done <= 1'b0;
        end else begin
            if (stp < 17) stp <= stp + 1;
            mul_done <= (stp == 16) && !stuck;
            if (stp == 16) mul_yout <= {16'h0, mul_ain} * {16'h0, mul_bin};
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int id; logic [31:0] data; int gcyc; int lat;} exp_t;
    exp_t q[$];
    int   glog[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_data = '0;

    bit [NREQ-1:0] pend = '0;
    bit [NREQ-1:0] keep = '0;
    logic [15:0]   av[NREQ];
    logic [15:0]   bv[NREQ];
    int            ptr_m = NREQ - 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
`ifdef SIGNED_MUL_EN
        logic signed [31:0] sa, sb;
        sa = $signed(a); sb = $signed(b);
        return sa * sb;
`else
        logic [31:0] ua, ub;
        ua = a; ub = b;
        return ua * ub;
`endif
    endfunction

    function automatic int predict(input logic [NREQ-1:0] r);
        for (int i = 1; i <= NREQ; i++)
            if (r[(ptr_m + i) % NREQ]) return (ptr_m + i) % NREQ;
        return -1;
    endfunction

    function automatic int gl_at(input int n);
        return (n < glog.size()) ? glog[n] : -1;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic apply();
        for (int k = 0; k < NREQ; k++) begin
            req[k] = pend[k];
            ain_flat[16*k +: 16] = av[k];
            bin_flat[16*k +: 16] = bv[k];
        end
    endtask

    // One cycle: predict and check any grant, push its response, then update requesters.
    task automatic step();
        int w;
        logic [NREQ-1:0] ev;
        w = -1;
        @(negedge clk);
        if (rst_n && gnt !== '0) begin
            w  = predict(req);
            ev = (w < 0) ? '0 : (NREQ'(1) << w);
            chk("gnt_winner", gnt, ev);
            if (w >= 0) begin
                q.push_back('{id: w, data: stuck ? 32'h0 : prod(av[w], bv[w]),
                              gcyc: cyc, lat: stuck ? TO + 1 : NOM_LAT});
                glog.push_back(w);
                ptr_m = w;
            end
        end
        @(posedge clk); #1;
        if (w >= 0) begin
            if (keep[w]) begin av[w] = rnd16(); bv[w] = rnd16(); end
            else pend[w] = 1'b0;
        end
        apply();
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((pend != '0 || q.size() != 0 || busy) && n < maxc) begin
            step(); n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, queue %0d", n, q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("reset_outputs",
            {gnt, rsp_valid, rsp_id, rsp_data, busy, err_timeout, mul_start, mul_ain, mul_bin}, '0);
        q.delete();
        pend = '0; keep = '0; stuck = 1'b0; ptr_m = NREQ - 1;
        apply();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pop and compare on every response; check release and no-overlap rules.
    bit prev_rsp = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rsp = 1'b0;
        end else begin
            if (prev_rsp) chk("mul_start_release", mul_start, 1'b0);
            if (gnt !== '0) chk("gnt_while_mul_busy", mul_start, 1'b0);
            if (rsp_valid) begin
                last_data = rsp_data;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got id %0d data %0h, expected none", rsp_id, rsp_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_latency", cyc - e.gcyc, e.lat);
                    chk("mul_start_in_resp", mul_start, 1'b1);
                end
            end
            prev_rsp = rsp_valid;
        end
    end

    initial begin
        int n, n0;
        for (int k = 0; k < NREQ; k++) begin av[k] = '0; bv[k] = '0; end
        apply();
        do_reset();

        // Single request
        av[0] = 16'd3; bv[0] = 16'd5; pend[0] = 1'b1; apply();
        drain(200);
        chk("single_product", last_data, 32'd15);

        // Simultaneous requests from a fresh pointer
        do_reset();
        n0 = glog.size();
        for (int k = 0; k < NREQ; k++) begin av[k] = 16'(k + 1); bv[k] = 16'hFFFF; end
        pend = '1; apply();
        drain(400);
        for (int k = 0; k < NREQ; k++) chk("simul_order", gl_at(n0 + k), k);

        // Fairness: lane 1 continuous, lane 2 arrives mid-operation
        n0 = glog.size();
        keep[1] = 1'b1; pend[1] = 1'b1; av[1] = 16'd7; bv[1] = 16'd9; apply();
        n = 0;
        while (glog.size() == n0 && n < 100) begin step(); n++; end
        repeat (5) step();
        n0 = glog.size();
        pend[2] = 1'b1; av[2] = 16'd11; bv[2] = 16'd13; apply();
        n = 0;
        while (pend[2] && n < 200) begin step(); n++; end
        chk("fair_next_grant", gl_at(n0), 2);
        keep[1] = 1'b0;
        drain(400);

        // Corner values
        av[3] = 16'hFFFF; bv[3] = 16'hFFFF; pend[3] = 1'b1; apply();
        drain(200);
`ifdef SIGNED_MUL_EN
        chk("corner_ffff", last_data, 32'h0000_0001);
        av[3] = 16'h8000; bv[3] = 16'hFFFF; pend[3] = 1'b1; apply();
        drain(200);
        chk("corner_8000", last_data, 32'h0000_8000);
        av[3] = 16'hFFFD; bv[3] = 16'd7; pend[3] = 1'b1; apply();
        drain(200);
        chk("corner_neg3x7", last_data, 32'hFFFF_FFEB);
`else
        chk("corner_ffff", last_data, 32'hFFFE_0001);
`endif

        // Watchdog
        chk("err_before_timeout", err_timeout, 1'b0);
        stuck = 1'b1;
        av[0] = 16'd100; bv[0] = 16'd100; pend[0] = 1'b1; apply();
        drain(200);
        chk("err_timeout_set", err_timeout, 1'b1);
        chk("timeout_data", last_data, 32'h0);
        stuck = 1'b0;
        av[2] = 16'd21; bv[2] = 16'd2; pend[2] = 1'b1; apply();
        drain(200);
        chk("after_timeout_data", last_data, 32'd42);
        chk("err_timeout_sticky", err_timeout, 1'b1);

        // Reset during RUN
        av[3] = 16'd5; bv[3] = 16'd5; pend[3] = 1'b1; apply();
        n = 0;
        while (!mul_start && n < 20) begin step(); n++; end
        chk("run_reached", mul_start, 1'b1);
        repeat (4) step();
        do_reset();
        chk("err_cleared_by_reset", err_timeout, 1'b0);
        n0 = glog.size();
        av[2] = 16'd2; bv[2] = 16'd3; av[3] = 16'd4; bv[3] = 16'd5;
        pend = 4'b1100; apply();
        drain(400);
        chk("post_reset_first", gl_at(n0), 2);

        // Randomised traffic with withdrawals
        for (int it = 0; it < 1500; it++) begin
            step();
            for (int k = 0; k < NREQ; k++) begin
                if (!pend[k] && $urandom_range(0, 7) == 0) begin
                    av[k] = rnd16(); bv[k] = rnd16(); pend[k] = 1'b1;
                end else if (pend[k] && $urandom_range(0, 29) == 0) begin
                    pend[k] = 1'b0;
                end
            end
            apply();
        end
        drain(2000);
        chk("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul16_rr_sched.md
Name: mul16_rr_sched

Overview:
- Round-robin scheduler that shares one 16x16 sequential shift-add multiplier (mux_16) among NREQ requesters, e.g. DBN neuron lanes.
- Accepts operand pairs with a req/gnt handshake and drives the multiplier's level-held start.
- Waits for the done pulse and returns the 32-bit product tagged with the requester id.
- Includes a timeout watchdog on the multiplier.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester id width; must equal ceil(log2(NREQ)).
- TIMEOUT, 31, cycles allowed from mul_start rise to mul_done before error.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester request level.
- ain_flat  in  16*NREQ  operand A, requester k in bits [16k+15:16k].
- bin_flat  in  16*NREQ  operand B, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse; operands of that requester captured this cycle.
- rsp_valid  out  1  one-cycle pulse; rsp_id/rsp_data valid.
- rsp_id  out  IDW  id of requester owning rsp_data.
- rsp_data  out  32  product.
- busy  out  1  high in any state except IDLE.
- err_timeout  out  1  sticky timeout flag, cleared only by reset.
- mul_start  out  1  to multiplier start; held high for the whole operation.
- mul_ain  out  16  to multiplier ain; registered, stable while mul_start high.
- mul_bin  out  16  to multiplier bin; registered.
- mul_yout  in  32  from multiplier yout.
- mul_done  in  1  from multiplier done.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer = NREQ-1 (so requester 0 wins first), timeout counter 0.

States IDLE, GRANT, RUN, RESP, RELEASE:
- IDLE: if any req bit is high, pick the winner by round-robin, searching from ptr+1 upward with wrap to 0. Go to GRANT.
- GRANT (1 cycle):
  - gnt[winner]=1.
  - Register the winner's operands into mul_ain/mul_bin.
  - Latch the id; ptr<=winner.
  - Go to RUN.
- RUN:
  - mul_start=1.
  - Counter increments each cycle.
  - On mul_done=1: capture mul_yout into rsp_data and go to RESP.
  - If the counter reaches TIMEOUT first: set err_timeout, rsp_data<=0, go to RESP.
- RESP (1 cycle): rsp_valid=1, rsp_id=latched id. mul_start stays high.
- RELEASE (1 cycle):
  - mul_start=0, so the multiplier's step counter returns to 0.
  - Counter cleared.
  - Go to IDLE.

Timing and handshake rules:
- Throughput: one product per (~17 multiplier cycles + 4) cycles.
- Latency: gnt to rsp_valid is nominally 19 cycles (mul_done ~17 cycles after mul_start rises).
- Requester holds req and operands until it sees gnt. Dropping req before gnt withdraws with no side effect.
- req still high after gnt is treated as a new request; it competes again in the next IDLE.
- Simultaneous requests: exactly one gnt per operation, with round-robin fairness. A continuously requesting lane waits at most NREQ-1 operations.
- No rsp backpressure: consumer must accept rsp_valid in its cycle.
- mul_done outside RUN is ignored.

Reset:
- Asynchronous reset mid-operation aborts without a response.
- The multiplier shares rst_n and also resets.

Optional Feature:
- Macro SIGNED_MUL_EN.
- Defined:
  - Operands are two's complement.
  - GRANT loads mul_ain/mul_bin with the magnitudes (-32768 gives 16'h8000, which is valid unsigned) and latches sign = a[15]^b[15].
  - On capture, rsp_data = sign ? -mul_yout : mul_yout, as 32-bit two's complement.
- Undefined: operands are unsigned and passed through unchanged; no sign logic.

Decomposition:
- Package mul16_sched_pkg:
  - state enum (IDLE, GRANT, RUN, RESP, RELEASE).
  - MUL_W=16 and PROD_W=32.
  - default TIMEOUT constant.
- One natural sub-module: rr_arbiter_n. Inputs: req vector and pointer. Outputs: one-hot winner and encoded id; purely combinational.
- The FSM and datapath stay in mul16_rr_sched.

Test Plan:
- Single request: req[0]=1, a=16'd3, b=16'd5.
  - Expect: gnt[0] pulse, then rsp_valid with rsp_id=0, rsp_data=32'd15.
  - Expect: mul_start low for exactly 1 cycle after RESP.
- Simultaneous requests: req=4'b1111, lane k has a=k+1, b=16'hFFFF.
  - Expect: grants in order 0,1,2,3, each rsp_data=(k+1)*65535.
  - Expect: no overlap of mul_start ops.
- Fairness: lane 1 requests continuously, lane 2 requests once mid-operation.
  - Expect: lane 2 is granted on the next arbitration, not lane 1.
- Corner values: a=16'hFFFF, b=16'hFFFF.
  - Expect: rsp_data=32'hFFFE0001.
  - With SIGNED_MUL_EN: a=16'h8000, b=16'hFFFF gives 32'h00008000; a=-3, b=7 gives 32'hFFFFFFEB.
- Timeout: stub mul_done stuck at 0.
  - Expect: after TIMEOUT cycles in RUN, err_timeout=1 and rsp_valid with rsp_data=0.
  - Expect: the next request is still served.
- Reset: assert rst_n=0 during RUN.
  - Expect: all outputs 0 immediately, no rsp_valid.
  - After release, first grant goes to the lowest requesting index.
